// File: rtl/tnn_feature_framer_pkg.sv
// Shared types and defaults for the TNN feature framer: FSM states, widths,
// and a helper that pulls one feature's threshold triple out of the packed table.
package tnn_frame_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        EVAL    = 2'd2,
        OUT     = 2'd3
    } state_e;

    localparam int DEF_N_FEAT = 5;
    localparam int DEF_RAW_W  = 8;
    localparam int DEF_Q_W    = 2;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_THR_W  = 3 * DEF_RAW_W;

    // Triple is {T3,T2,T1}, lowest threshold in the low byte.
    function automatic logic [DEF_THR_W-1:0] thr_slice(
        input logic [DEF_N_FEAT*DEF_THR_W-1:0] thr,
        input int                              k
    );
        return thr[k*DEF_THR_W +: DEF_THR_W];
    endfunction

endpackage

// File: rtl/tnn_feature_framer_if.sv
// Raw feature stream in and class result stream out, bundled for the framer.
interface tnn_feature_framer_if #(
    parameter int RAW_W = 8
) ();
    logic             s_valid;
    logic             s_ready;
    logic [RAW_W-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic             m_class;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class
    );
endinterface

// File: rtl/tnn_feature_framer_quant.sv
// Three-threshold quantizer: counts how many thresholds the raw value meets,
// so a value equal to a threshold lands in the upper bin.
module tnn_thr_quant #(
    parameter int RAW_W = 8
) (
    input  logic [RAW_W-1:0]   x_i,
    input  logic [3*RAW_W-1:0] thr_i,
    output logic [1:0]         q_o
);
    logic ge1, ge2, ge3;

    assign ge1 = (x_i >= thr_i[0*RAW_W +: RAW_W]);
    assign ge2 = (x_i >= thr_i[1*RAW_W +: RAW_W]);
    assign ge3 = (x_i >= thr_i[2*RAW_W +: RAW_W]);
    assign q_o = {1'b0, ge1} + {1'b0, ge2} + {1'b0, ge3};
endmodule

// File: rtl/tnn_feature_framer.sv
// Frames raw feature beats into one quantized sample for the TNN classifier,
// registers the returned class bit and hands it downstream with usage counters.
module tnn_feature_framer
    import tnn_frame_pkg::*;
#(
    parameter int                        N_FEAT = DEF_N_FEAT,
    parameter int                        RAW_W  = DEF_RAW_W,
    parameter int                        Q_W    = DEF_Q_W,
    parameter logic [N_FEAT*3*RAW_W-1:0] THR    = {N_FEAT{8'd192, 8'd128, 8'd64}},
    parameter int                        CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tnn_feature_framer_if.slave     bus,
    output logic [N_FEAT*Q_W-1:0]   cls_feat,
    input  logic                    cls_in,
    output logic                    err_frame,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        pos_cnt
);
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int THR_W = 3 * RAW_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

    state_e                         state_q;
    logic [IDX_W-1:0]               idx_q;
    logic [N_FEAT-1:0][Q_W-1:0]     slot_q, slot_d;
    logic [N_FEAT-1:0][Q_W-1:0]     cls_feat_q;
    logic                           s_ready_q;
    logic                           m_valid_q;
    logic                           m_class_q;
    logic                           err_q;
    logic [CNT_W-1:0]               sample_cnt_q;
    logic [CNT_W-1:0]               pos_cnt_q;

    logic [THR_W-1:0]               thr_sel;
    logic [1:0]                     q;
    logic                           accept;
    logic                           idx_last;
    logic                           handoff;

    // One shared quantizer; thresholds follow the slot being filled.
    assign thr_sel = THR[32'(idx_q)*THR_W +: THR_W];

    tnn_thr_quant #(.RAW_W(RAW_W)) u_quant (
        .x_i   (bus.s_data),
        .thr_i (thr_sel),
        .q_o   (q)
    );

    assign accept   = bus.s_valid & s_ready_q;
    assign idx_last = (idx_q == IDX_LAST);
    assign handoff  = m_valid_q & bus.m_ready;

    // Slot image including the beat being accepted this cycle, so the final
    // beat can go straight into cls_feat without an extra cycle.
    always_comb begin
        slot_d        = slot_q;
        slot_d[idx_q] = Q_W'(q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            slot_q       <= '0;
            cls_feat_q   <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_class_q    <= 1'b0;
            err_q        <= 1'b0;
            sample_cnt_q <= '0;
            pos_cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                COLLECT: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        slot_q <= slot_d;
                        if (idx_last) begin
                            idx_q <= '0;
                            if (bus.s_last) begin
                                s_ready_q  <= 1'b0;
                                cls_feat_q <= slot_d;
                                state_q    <= EVAL;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= DISCARD;
                            end
                        end else if (bus.s_last) begin
                            err_q <= 1'b1;
                            idx_q <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    s_ready_q <= 1'b1;
                    if (accept && bus.s_last) state_q <= COLLECT;
                end
                EVAL: begin
                    // cls_feat has been stable for a full cycle; the classifier has settled.
                    m_class_q <= cls_in;
                    m_valid_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (handoff) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= COLLECT;
                        if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + 1'b1;
                        if (m_class_q && (pos_cnt_q != '1)) pos_cnt_q <= pos_cnt_q + 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;
    assign cls_feat    = cls_feat_q;
    assign err_frame   = err_q;
    assign sample_cnt  = sample_cnt_q;
    assign pos_cnt     = pos_cnt_q;

endmodule
